avalon_mem_if_reg_slice: RTL and testbench
==========================================

// Module: avalon_mem_if_reg_slice
// PURPOSE
//   Registered pipeline stage between an AFU-side and an FIU-side Avalon-MM
//   memory port, placed in series with the direct-wire connect for timing closure.
//   Command path (read/write/address/burstcount/writedata/byteenable) uses a
//   2-entry skid buffer so afu_waitrequest is a flop output.
//   Response path (readdata/readdatavalid) is a single register with no backpressure.
// PARAMETERS
//   ADDR_WIDTH      27   word address width
//   DATA_WIDTH      512  readdata/writedata width; byteenable is DATA_WIDTH/8
//   BURST_CNT_WIDTH 7    burstcount width
// PORTS
//   clk               in   1               single clock for both sides
//   reset_n           in   1               async assert, active-low
//   afu_waitrequest   out  1               slice cannot accept a command this cycle
//   afu_read          in   1               read command valid
//   afu_write         in   1               write beat valid
//   afu_address       in   ADDR_WIDTH      command address
//   afu_burstcount    in   BURST_CNT_WIDTH burst length, 1..2^(W-1)
//   afu_writedata     in   DATA_WIDTH      write beat data
//   afu_byteenable    in   DATA_WIDTH/8    write byte mask
//   afu_readdata      out  DATA_WIDTH      registered read data
//   afu_readdatavalid out  1               registered read data valid
//   fiu_waitrequest   in   1               FIU stall
//   fiu_read/fiu_write out 1 each          forwarded command valids
//   fiu_address, fiu_burstcount, fiu_writedata, fiu_byteenable  out  (widths as afu_*)
//   fiu_readdata      in   DATA_WIDTH      FIU read data
//   fiu_readdatavalid in   1               FIU read data valid
// BEHAVIOUR
//   - Reset (reset_n low, async): main_valid=0, skid_valid=0, fiu_read=fiu_write=0,
//     afu_readdatavalid=0, afu_waitrequest=1. Data regs don't-care.
//     afu_waitrequest drops to 0 on the first clk edge after release.
//   - AFU accept: (afu_read|afu_write) && !afu_waitrequest.
//     FIU accept: (fiu_read|fiu_write) && !fiu_waitrequest.
//   - fiu_* command outputs come straight from the main register;
//     fiu_read/fiu_write are gated by main_valid.
//   - Main register advance: main is empty OR FIU accepts this cycle.
//     On advance, main loads skid if skid_valid, else the AFU input if AFU accept,
//     else clears main_valid.
//   - Skid load: AFU accept while main is full and not advancing.
//     Skid drains into main on the next advance.
//   - afu_waitrequest(next) = skid_valid(next). Registered; never comb from fiu_waitrequest.
//   - Command latency: AFU accept at cycle N -> on FIU at N+1 when unstalled.
//     Throughput is 1 command/cycle sustained.
//   - Ordering is strict FIFO; write bursts pass beat-by-beat unchanged.
//     The slice never splits, merges or reorders commands.
//   - Simultaneous skid drain and new AFU accept cannot occur: afu_waitrequest=1 while skid full.
//   - afu_read && afu_write together is illegal. A simulation-only assertion fires;
//     RTL forwards both unchanged.
//   - Response: afu_readdata/afu_readdatavalid <= fiu_readdata/fiu_readdatavalid every cycle.
//     Latency is exactly 1 cycle. afu_readdata updates only when fiu_readdatavalid=1.
//   - Reset mid-operation drops buffered commands and any in-flight response.
//     No outstanding-read tracking.
//   - Command payload registers load only on valid transfers, with no reset on data.
// TESTING
//   1. Reset release, idle: afu_waitrequest 1 -> 0 one cycle after reset_n rises;
//      fiu_read=fiu_write=0.
//   2. Read addr 0x100 burst 4, fiu_waitrequest=0: fiu_read=1 with addr 0x100,
//      bc 4 on the next cycle only.
//   3. 4-beat write burst, data 0xA0..0xA3, fiu_waitrequest held 1 from beat 2:
//      afu_waitrequest=1 after beat 3 is accepted into skid. Release fiu_waitrequest:
//      FIU sees A0,A1,A2,A3 in order, no loss or duplication.
//   4. Back-to-back read/write/read with fiu_waitrequest toggling pseudo-randomly
//      for 1000 cycles: FIU command stream equals AFU accepted stream
//      (scoreboard), 100% throughput when never stalled.
//   5. fiu_readdatavalid pulses with data 0x55 then 0xAA: afu_readdatavalid and
//      afu_readdata match each one cycle later.
//   6. reset_n low while main and skid both full: fiu_read/fiu_write and
//      afu_readdatavalid go 0 immediately (async); no stale command after release.

Source files
------------

// File: rtl/avalon_mem_if_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : avalon_mem_if_reg_slice
// Description : Avalon-MM register slice between AFU and FIU ports.
//               Command path uses a 2-entry skid buffer, response path is
//               a single register.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_mem_if_reg_slice #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7
) (
    input  logic                        clk,
    input  logic                        reset_n,

    output logic                        afu_waitrequest,
    input  logic                        afu_read,
    input  logic                        afu_write,
    input  logic [ADDR_WIDTH-1:0]       afu_address,
    input  logic [BURST_CNT_WIDTH-1:0]  afu_burstcount,
    input  logic [DATA_WIDTH-1:0]       afu_writedata,
    input  logic [DATA_WIDTH/8-1:0]     afu_byteenable,
    output logic [DATA_WIDTH-1:0]       afu_readdata,
    output logic                        afu_readdatavalid,

    input  logic                        fiu_waitrequest,
    output logic                        fiu_read,
    output logic                        fiu_write,
    output logic [ADDR_WIDTH-1:0]       fiu_address,
    output logic [BURST_CNT_WIDTH-1:0]  fiu_burstcount,
    output logic [DATA_WIDTH-1:0]       fiu_writedata,
    output logic [DATA_WIDTH/8-1:0]     fiu_byteenable,
    input  logic [DATA_WIDTH-1:0]       fiu_readdata,
    input  logic                        fiu_readdatavalid
);

    localparam int c_CMD_W = 2 + ADDR_WIDTH + BURST_CNT_WIDTH + DATA_WIDTH + DATA_WIDTH/8;

    logic               r_main_valid;
    logic               r_skid_valid;
    logic               r_afu_waitrequest;
    logic [c_CMD_W-1:0] r_main_cmd;
    logic [c_CMD_W-1:0] r_skid_cmd;
    logic               r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic               w_afu_accept;
    logic               w_fiu_accept;
    logic               w_main_adv;
    logic               w_skid_load;
    logic               w_skid_valid_nxt;
    logic [c_CMD_W-1:0] w_afu_cmd;

    assign w_afu_cmd = {afu_read, afu_write, afu_address, afu_burstcount,
                        afu_writedata, afu_byteenable};

    assign fiu_read  = r_main_valid & r_main_cmd[c_CMD_W-1];
    assign fiu_write = r_main_valid & r_main_cmd[c_CMD_W-2];
    assign {fiu_address, fiu_burstcount, fiu_writedata, fiu_byteenable} =
        r_main_cmd[c_CMD_W-3:0];

    assign afu_waitrequest   = r_afu_waitrequest;
    assign afu_readdata      = r_rd_data;
    assign afu_readdatavalid = r_rd_valid;

    always_comb begin
        w_afu_accept     = (afu_read | afu_write) & ~r_afu_waitrequest;
        w_fiu_accept     = (fiu_read | fiu_write) & ~fiu_waitrequest;
        w_main_adv       = ~r_main_valid | w_fiu_accept;
        w_skid_load      = w_afu_accept & ~w_main_adv;
        // waitrequest is high whenever skid is full, so a drain and a new accept never coincide
        w_skid_valid_nxt = r_skid_valid ? ~w_main_adv : w_skid_load;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main_valid      <= 1'b0;
            r_skid_valid      <= 1'b0;
            r_afu_waitrequest <= 1'b1;
            r_rd_valid        <= 1'b0;
        end else begin
            if (w_main_adv) begin
                r_main_valid <= r_skid_valid | w_afu_accept;
            end
            r_skid_valid      <= w_skid_valid_nxt;
            r_afu_waitrequest <= w_skid_valid_nxt;
            r_rd_valid        <= fiu_readdatavalid;
        end
    end

    // Payload registers carry no reset; validity is tracked by the flags above.
    always_ff @(posedge clk) begin
        if (w_main_adv) begin
            if (r_skid_valid) begin
                r_main_cmd <= r_skid_cmd;
            end else if (w_afu_accept) begin
                r_main_cmd <= w_afu_cmd;
            end
        end
        if (w_skid_load) begin
            r_skid_cmd <= w_afu_cmd;
        end
        if (fiu_readdatavalid) begin
            r_rd_data <= fiu_readdata;
        end
    end

`ifndef SYNTHESIS
    a_no_read_and_write : assert property (@(posedge clk) disable iff (!reset_n)
        !(afu_read && afu_write))
        else $error("afu_read and afu_write asserted together");
`endif

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_if_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_mem_if_reg_slice
// Description : Directed self-checking bench for avalon_mem_if_reg_slice.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_if_reg_slice;

    localparam int ADDR_WIDTH      = 27;
    localparam int DATA_WIDTH      = 32;
    localparam int BURST_CNT_WIDTH = 7;

    typedef struct packed {
        logic                       rd;
        logic                       wr;
        logic [ADDR_WIDTH-1:0]      addr;
        logic [BURST_CNT_WIDTH-1:0] bc;
        logic [DATA_WIDTH-1:0]      wd;
        logic [DATA_WIDTH/8-1:0]    be;
    } cmd_t;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic                       afu_waitrequest;
    logic                       afu_read;
    logic                       afu_write;
    logic [ADDR_WIDTH-1:0]      afu_address;
    logic [BURST_CNT_WIDTH-1:0] afu_burstcount;
    logic [DATA_WIDTH-1:0]      afu_writedata;
    logic [DATA_WIDTH/8-1:0]    afu_byteenable;
    logic [DATA_WIDTH-1:0]      afu_readdata;
    logic                       afu_readdatavalid;
    logic                       fiu_waitrequest;
    logic                       fiu_read;
    logic                       fiu_write;
    logic [ADDR_WIDTH-1:0]      fiu_address;
    logic [BURST_CNT_WIDTH-1:0] fiu_burstcount;
    logic [DATA_WIDTH-1:0]      fiu_writedata;
    logic [DATA_WIDTH/8-1:0]    fiu_byteenable;
    logic [DATA_WIDTH-1:0]      fiu_readdata;
    logic                       fiu_readdatavalid;

    int checks = 0;
    int errors = 0;
    int afu_acc_cnt = 0;
    int fiu_acc_cnt = 0;
    cmd_t sb[$];
    logic [DATA_WIDTH-1:0] wseen[$];

    always #5 clk = ~clk;

    avalon_mem_if_reg_slice #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .BURST_CNT_WIDTH (BURST_CNT_WIDTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .afu_waitrequest   (afu_waitrequest),
        .afu_read          (afu_read),
        .afu_write         (afu_write),
        .afu_address       (afu_address),
        .afu_burstcount    (afu_burstcount),
        .afu_writedata     (afu_writedata),
        .afu_byteenable    (afu_byteenable),
        .afu_readdata      (afu_readdata),
        .afu_readdatavalid (afu_readdatavalid),
        .fiu_waitrequest   (fiu_waitrequest),
        .fiu_read          (fiu_read),
        .fiu_write         (fiu_write),
        .fiu_address       (fiu_address),
        .fiu_burstcount    (fiu_burstcount),
        .fiu_writedata     (fiu_writedata),
        .fiu_byteenable    (fiu_byteenable),
        .fiu_readdata      (fiu_readdata),
        .fiu_readdatavalid (fiu_readdatavalid)
    );

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic rd, input logic wr, input logic [ADDR_WIDTH-1:0] a,
                           input logic [BURST_CNT_WIDTH-1:0] bc, input logic [DATA_WIDTH-1:0] wd);
        afu_read       = rd;
        afu_write      = wr;
        afu_address    = a;
        afu_burstcount = bc;
        afu_writedata  = wd;
        afu_byteenable = wd[DATA_WIDTH/8-1:0] ^ {(DATA_WIDTH/8){1'b1}};
    endtask

    // Records both handshakes seen before the coming edge, then advances one cycle.
    task automatic cycle();
        cmd_t got;
        cmd_t exp;
        if ((afu_read || afu_write) && !afu_waitrequest) begin
            sb.push_back({afu_read, afu_write, afu_address, afu_burstcount,
                          afu_writedata, afu_byteenable});
            afu_acc_cnt++;
        end
        if ((fiu_read || fiu_write) && !fiu_waitrequest) begin
            fiu_acc_cnt++;
            got = {fiu_read, fiu_write, fiu_address, fiu_burstcount,
                   fiu_writedata, fiu_byteenable};
            if (fiu_write) wseen.push_back(fiu_writedata);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed %0h expected none", got);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("sb_order", 128'(got), 128'(exp));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int acc_start;
        int stale;
        int wr_seen_cnt;
        logic have_cmd;
        logic acc;

        reset_n           = 1'b0;
        fiu_waitrequest   = 1'b0;
        fiu_readdata      = '0;
        fiu_readdatavalid = 1'b0;
        set_cmd(1'b0, 1'b0, '0, '0, '0);

        // 1. reset and release
        repeat (2) @(negedge clk);
        check("rst_waitreq", 128'(afu_waitrequest), 128'(1));
        check("rst_fiu_rw", 128'({fiu_read, fiu_write}), 128'(0));
        check("rst_rdvalid", 128'(afu_readdatavalid), 128'(0));
        reset_n = 1'b1;
        #1;
        check("rel_waitreq_hold", 128'(afu_waitrequest), 128'(1));
        @(negedge clk);
        check("rel_waitreq_drop", 128'(afu_waitrequest), 128'(0));
        check("rel_fiu_idle", 128'({fiu_read, fiu_write}), 128'(0));

        // 2. single read, one-cycle latency
        set_cmd(1'b1, 1'b0, 27'h100, 7'd4, 32'h0);
        cycle();
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        check("rd_fiu_read", 128'(fiu_read), 128'(1));
        check("rd_fiu_write", 128'(fiu_write), 128'(0));
        check("rd_addr", 128'(fiu_address), 128'(27'h100));
        check("rd_bc", 128'(fiu_burstcount), 128'(4));
        cycle();
        check("rd_one_cycle", 128'(fiu_read), 128'(0));

        // 3. write burst with stall filling the skid
        wseen.delete();
        set_cmd(1'b0, 1'b1, 27'h200, 7'd4, 32'hA0);
        cycle();
        set_cmd(1'b0, 1'b1, 27'h200, 7'd4, 32'hA1);
        cycle();
        check("wb_wait_after_b2", 128'(afu_waitrequest), 128'(0));
        fiu_waitrequest = 1'b1;
        set_cmd(1'b0, 1'b1, 27'h200, 7'd4, 32'hA2);
        cycle();
        check("wb_wait_after_b3", 128'(afu_waitrequest), 128'(1));
        set_cmd(1'b0, 1'b1, 27'h200, 7'd4, 32'hA3);
        cycle();
        check("wb_wait_held", 128'(afu_waitrequest), 128'(1));
        check("wb_fiu_data_held", 128'(fiu_writedata), 128'(32'hA1));
        fiu_waitrequest = 1'b0;
        for (int i = 0; i < 6; i++) begin
            acc = afu_write && !afu_waitrequest;
            cycle();
            if (acc) set_cmd(1'b0, 1'b0, '0, '0, '0);
        end
        check("wb_beats", 128'(wseen.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < wseen.size()) check("wb_beat_data", 128'(wseen[i]), 128'(32'hA0 + i));
        end

        // 4a. random mixed traffic with random FIU stalls
        have_cmd = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!have_cmd) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_cmd(1'b0, 1'b0, '0, '0, '0);
                end else begin
                    have_cmd = 1'b1;
                    if ($urandom_range(0, 1) == 1)
                        set_cmd(1'b1, 1'b0, 27'($urandom), 7'($urandom_range(1, 64)), 32'($urandom));
                    else
                        set_cmd(1'b0, 1'b1, 27'($urandom), 7'($urandom_range(1, 64)), 32'($urandom));
                end
            end
            fiu_waitrequest = 1'($urandom_range(0, 1));
            acc = (afu_read || afu_write) && !afu_waitrequest;
            cycle();
            if (acc) begin
                have_cmd = 1'b0;
                set_cmd(1'b0, 1'b0, '0, '0, '0);
            end
        end
        if (have_cmd) begin
            for (int i = 0; i < 4 && (afu_read || afu_write); i++) begin
                acc = !afu_waitrequest;
                cycle();
                if (acc) set_cmd(1'b0, 1'b0, '0, '0, '0);
            end
        end
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        fiu_waitrequest = 1'b0;
        repeat (4) cycle();
        check("rand_drained", 128'(sb.size()), 128'(0));
        check("rand_cnt", 128'(fiu_acc_cnt), 128'(afu_acc_cnt));

        // 4b. full throughput without stalls
        acc_start = afu_acc_cnt;
        stale = 0;
        for (int i = 0; i < 50; i++) begin
            set_cmd(1'b1, 1'b0, 27'(i + 16), 7'd1, '0);
            if (afu_waitrequest) stale++;
            cycle();
        end
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        check("tput_accepts", 128'(afu_acc_cnt - acc_start), 128'(50));
        check("tput_no_wait", 128'(stale), 128'(0));
        repeat (3) cycle();
        check("tput_drained", 128'(sb.size()), 128'(0));

        // 5. response path
        fiu_readdata = 32'h55; fiu_readdatavalid = 1'b1;
        cycle();
        check("resp1_valid", 128'(afu_readdatavalid), 128'(1));
        check("resp1_data", 128'(afu_readdata), 128'(32'h55));
        fiu_readdata = 32'h77; fiu_readdatavalid = 1'b0;
        cycle();
        check("resp_gap_valid", 128'(afu_readdatavalid), 128'(0));
        check("resp_gap_data_hold", 128'(afu_readdata), 128'(32'h55));
        fiu_readdata = 32'hAA; fiu_readdatavalid = 1'b1;
        cycle();
        check("resp2_valid", 128'(afu_readdatavalid), 128'(1));
        check("resp2_data", 128'(afu_readdata), 128'(32'hAA));
        fiu_readdatavalid = 1'b0;
        cycle();

        // 6. async reset with main and skid full
        fiu_waitrequest = 1'b1;
        set_cmd(1'b0, 1'b1, 27'h300, 7'd2, 32'hC0);
        cycle();
        set_cmd(1'b0, 1'b1, 27'h300, 7'd2, 32'hC1);
        fiu_readdata = 32'h11; fiu_readdatavalid = 1'b1;
        cycle();
        fiu_readdatavalid = 1'b0;
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        check("full_waitreq", 128'(afu_waitrequest), 128'(1));
        check("full_fiu_write", 128'(fiu_write), 128'(1));
        check("full_rdvalid", 128'(afu_readdatavalid), 128'(1));
        #2 reset_n = 1'b0;
        #1;
        check("arst_fiu_rw", 128'({fiu_read, fiu_write}), 128'(0));
        check("arst_rdvalid", 128'(afu_readdatavalid), 128'(0));
        check("arst_waitreq", 128'(afu_waitrequest), 128'(1));
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        fiu_waitrequest = 1'b0;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (fiu_read || fiu_write) stale++;
        end
        check("arst_no_stale", 128'(stale), 128'(0));
        check("arst_waitreq_clear", 128'(afu_waitrequest), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
